reg_vector_table: RTL
=====================

# reg_vector_table

Parametrised successor to the constant register block. It provides DEPTH word-wide entries on two tristate read ports. Entries below NUM_CONST are hardwired to their own index; the remaining entries are writable registers. It also contains a small interrupt front-end: it captures the lowest-numbered asserted IRQ line and presents that line's vector (a writable table entry) to the control unit, holding it until acknowledged.

## Interface
- WORD_SIZE, 32, data width of entries and ports
- SEL_WIDTH, 4, select width
- DEPTH, 2**SEL_WIDTH, number of entries
- NUM_CONST, 3, entries 0..NUM_CONST-1 read as constant value = index (0, 1 HWINT, 2 SWINT)
- NUM_IRQ, 4, IRQ lines; line k's vector is entry NUM_CONST+k
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  output tri  WORD_SIZE  read port A, drives entry sel_a when oe_a, else 'z
- b  output tri  WORD_SIZE  read port B, drives entry sel_b when oe_b, else 'z
- oe_a, oe_b  input  1  output enables
- sel_a, sel_b  input  SEL_WIDTH  read selects
- in  input  WORD_SIZE  write data
- ld  input  1  write strobe
- sel_in  input  SEL_WIDTH  write select
- irq  input  NUM_IRQ  level-sensitive interrupt requests
- irq_ack  input  1  acknowledge of current interrupt
- irq_pending  output  1  registered, high while an interrupt is held
- irq_vector  output  WORD_SIZE  vector of the held interrupt, 0 when none held
- lock  input  1  only with REG_VECTOR_LOCK_EN; sticky write lock

## Operation
- Elaboration check: NUM_CONST+NUM_IRQ <= DEPTH, and NUM_CONST >= 1. Violating either is a fatal elaboration error.
- Writable entries (index >= NUM_CONST) reset to 0.
- Writes: on a clock edge with ld=1 and sel_in >= NUM_CONST, entry[sel_in] <= in. Writes to constant entries are silently dropped.
- Reads are combinational from stored state. There is no write bypass: a read of the entry being written returns the old value until the edge.
- Both ports may select the same entry at the same time.
- Interrupt FSM has two states, IRQ_IDLE and IRQ_PEND. Reset state is IRQ_IDLE.
- IRQ_IDLE: if irq != 0 at an edge, cur_id <= index of the lowest set bit, and the FSM moves to IRQ_PEND. irq_ack is ignored in this state.
- IRQ_PEND: irq_pending=1 and irq_vector = entry[NUM_CONST+cur_id]. irq_vector tracks this entry live, so a write to it shows the following cycle.
- In IRQ_PEND, changes on irq are ignored.
- IRQ_PEND exits to IRQ_IDLE on an edge with irq_ack=1.
- After an exit, the FSM spends at least one cycle in IRQ_IDLE before it can capture again. A device must hold irq until it is serviced.
- Reset mid-operation: all writable entries clear, the FSM returns to IRQ_IDLE, irq_pending=0, irq_vector=0. Ports a and b stay governed only by oe_a and oe_b.

## Timing
- Write latency is 1 edge.
- Read latency is 0 cycles (combinational).
- IRQ latency: irq sampled high at edge N gives irq_pending=1 after edge N.
- Ack latency: irq_ack sampled at edge M gives irq_pending=0 after edge M. The earliest next capture is edge M+1, so the next pending appears after edge M+1.
- Reset values: irq_pending 0, irq_vector 0, and a/b 'z when their enables are low.

## Configuration
- REG_VECTOR_LOCK_EN defined:
  - Adds the lock input and a lock_q flop (reset 0).
  - lock=1 at an edge sets lock_q. lock_q stays set until rst_n.
  - While lock_q=1, all writes are dropped.
  - A write and lock in the same cycle: the write commits and the lock applies from the next edge.
- REG_VECTOR_LOCK_EN undefined: there is no lock port and entries are always writable.

## Structure
- Package reg_vector_pkg holds:
  - enum irq_state_e {IRQ_IDLE, IRQ_PEND}
  - localparam default NUM_CONST=3
  - named constants HWINT_VEC=1 and SWINT_VEC=2
- Sub-module prio_enc, parametrised on width. It outputs the lowest-set-bit index plus a valid flag, and is instanced once for the irq vector.

## Test plan
- Reset, then read entries 0, 1, 2, 3 on a -> 0, 1, 2, 0; with oe_a=0 -> a is 'z.
- ld=1, sel_in=4, in=32'hDEAD_BEEF, same-cycle read of entry 4 on b -> old value 0, then 32'hDEAD_BEEF after the edge. ld to sel_in=1 -> entry 1 still reads 1.
- Write entry 3=32'h100 and entry 5=32'h300, raise irq=4'b0101 -> irq_pending after one edge, irq_vector=32'h100. Pulse irq_ack, hold irq=4'b0100 -> pending low for one cycle, then vector 32'h300.
- In IRQ_PEND, raise irq bit 0 while holding bit 2 -> vector unchanged until ack. irq_ack in IRQ_IDLE -> no effect.
- Assert rst_n=0 asynchronously while pending with entry 3 written -> irq_pending=0, irq_vector=0, entry 3 reads 0, all without a clock edge.
- REG_VECTOR_LOCK_EN: write entry 6=7 with lock=1 in the same cycle -> 6 reads 7. Then write entry 6=9 -> still 7. After reset, writes succeed.

Source files
------------

// File: rtl/reg_vector_pkg.sv
// reg_vector_pkg
//   Shared types and constants for the register vector table.
//   - irq_state_e       : interrupt front-end states
//   - DEFAULT_NUM_CONST : default count of hardwired entries
//   - HWINT_VEC/SWINT_VEC : fixed indices of the hardware/software
//                           interrupt constant entries
package reg_vector_pkg;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_e;

    localparam int unsigned DEFAULT_NUM_CONST = 3;
    localparam int unsigned HWINT_VEC         = 1;
    localparam int unsigned SWINT_VEC         = 2;

endpackage

// File: rtl/reg_vector_table_prio_enc.sv
// prio_enc
//   Lowest-set-bit priority encoder.
//   Ports:
//     req   in  WIDTH   request vector
//     idx   out IDX_W   index of the lowest set bit (0 when none set)
//     valid out 1       at least one request bit is set
module prio_enc
    import reg_vector_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (req[i-1]) begin
                idx   = IDX_W'(i - 1);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_vector_table.sv
// reg_vector_table
//   DEPTH-entry register table with two tristate read ports. Entries below
//   NUM_CONST read as their own index; the rest are writable registers that
//   reset to 0. An interrupt front-end captures the lowest asserted irq line
//   and presents entry NUM_CONST+line as irq_vector until irq_ack.
//   Optional feature macro: REG_VECTOR_LOCK_EN (adds sticky write lock).
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     a, b                  tristate read ports (driven when oe_a / oe_b)
//     oe_a, oe_b            read port output enables
//     sel_a, sel_b          read selects
//     in, ld, sel_in        write data, write strobe, write select
//     irq                   level-sensitive interrupt requests
//     irq_ack               acknowledge of the held interrupt
//     irq_pending           high while an interrupt is held
//     irq_vector            vector of the held interrupt, 0 when none
//     lock                  (REG_VECTOR_LOCK_EN only) sticky write lock
module reg_vector_table
    import reg_vector_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned SEL_WIDTH = 4,
    parameter int unsigned DEPTH     = 2 ** SEL_WIDTH,
    parameter int unsigned NUM_CONST = DEFAULT_NUM_CONST,
    parameter int unsigned NUM_IRQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output tri   [WORD_SIZE-1:0] a,
    output tri   [WORD_SIZE-1:0] b,
    input  logic                 oe_a,
    input  logic                 oe_b,
    input  logic [SEL_WIDTH-1:0] sel_a,
    input  logic [SEL_WIDTH-1:0] sel_b,
    input  logic [WORD_SIZE-1:0] in,
    input  logic                 ld,
    input  logic [SEL_WIDTH-1:0] sel_in,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic                 irq_ack,
    output logic                 irq_pending,
    output logic [WORD_SIZE-1:0] irq_vector
`ifdef REG_VECTOR_LOCK_EN
    ,
    input  logic                 lock
`endif
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    if (NUM_CONST + NUM_IRQ > DEPTH) begin : g_chk_irq_fit
        $fatal(1, "reg_vector_table: NUM_CONST + NUM_IRQ exceeds DEPTH");
    end
    if (NUM_CONST < 1) begin : g_chk_const
        $fatal(1, "reg_vector_table: NUM_CONST must be at least 1");
    end
    if (DEPTH > 2 ** SEL_WIDTH) begin : g_chk_sel
        $fatal(1, "reg_vector_table: DEPTH not addressable by SEL_WIDTH");
    end

    // ------------------------------------------------------------------
    // Write permission
    // ------------------------------------------------------------------
    logic wr_allow;

`ifdef REG_VECTOR_LOCK_EN
    logic lock_q;

    // The lock is sampled registered, so a write in the same cycle as
    // lock still commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (lock) begin
            lock_q <= 1'b1;
        end
    end

    assign wr_allow = ld & ~lock_q;
`else
    assign wr_allow = ld;
`endif

    // ------------------------------------------------------------------
    // Entry storage: constants below NUM_CONST, registers above
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] entry [DEPTH];

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
        if (i < int'(NUM_CONST)) begin : g_const
            assign entry[i] = WORD_SIZE'(i);
        end else begin : g_reg
            logic [WORD_SIZE-1:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (wr_allow && (sel_in == SEL_WIDTH'(i))) begin
                    q <= in;
                end
            end

            assign entry[i] = q;
        end
    end

    // ------------------------------------------------------------------
    // Read ports (combinational, no write bypass)
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] rd_a;
    logic [WORD_SIZE-1:0] rd_b;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (sel_a == SEL_WIDTH'(k)) begin
                rd_a = entry[k];
            end
            if (sel_b == SEL_WIDTH'(k)) begin
                rd_b = entry[k];
            end
        end
    end

    assign a = oe_a ? rd_a : 'z;
    assign b = oe_b ? rd_b : 'z;

    // ------------------------------------------------------------------
    // Interrupt front-end
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] irq_idx;
    logic             irq_valid;

    prio_enc #(
        .WIDTH (NUM_IRQ)
    ) u_prio (
        .req   (irq),
        .idx   (irq_idx),
        .valid (irq_valid)
    );

    irq_state_e       state_q;
    irq_state_e       state_d;
    logic [IDX_W-1:0] cur_id_q;
    logic [IDX_W-1:0] cur_id_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IRQ_IDLE;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
        end
    end

    // Leaving IRQ_PEND always lands in IRQ_IDLE for at least one cycle,
    // which gives the one-cycle gap between back-to-back interrupts.
    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        irq_pending = 1'b0;
        irq_vector  = '0;
        case (state_q)
            IRQ_IDLE: begin
                if (irq_valid) begin
                    state_d  = IRQ_PEND;
                    cur_id_d = irq_idx;
                end
            end
            IRQ_PEND: begin
                irq_pending = 1'b1;
                for (int unsigned k = 0; k < NUM_IRQ; k++) begin
                    if (cur_id_q == IDX_W'(k)) begin
                        irq_vector = entry[NUM_CONST + k];
                    end
                end
                if (irq_ack) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

endmodule
